axis_reg_slice: RTL and testbench



---
 rtl/axis_pkg.sv | 29 ++
 rtl/axis_skid_reg.sv | 52 +++++
 rtl/axis_reg_slice.sv | 206 ++++++++++++++++++++
 tb/tb_axis_reg_slice.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
// -----------------------------------------------------------------------------
// axis_pkg
// Shared definitions for the valid/ready register slice:
//   - slice mode constants (pass-through, forward, backward, full skid)
//   - state encoding of the two-entry full-skid controller
//   - width of the optional stall counter
// No ports (package).
// -----------------------------------------------------------------------------
package axis_pkg;

  localparam int MODE_PASS = 0;
  localparam int MODE_FWD  = 1;
  localparam int MODE_BWD  = 2;
  localparam int MODE_FULL = 3;

  localparam int STALL_CNT_W = 16;

  // Encoding chosen so the state value equals the number of beats held.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } full_state_e;

  function automatic bit mode_is_legal(input int mode);
    return (mode >= MODE_PASS) && (mode <= MODE_FULL);
  endfunction

endpackage

// File: rtl/axis_skid_reg.sv
// -----------------------------------------------------------------------------
// axis_skid_reg
// Single-entry hold register: one payload plus its valid flag.
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset (valid=0, data=0)
//   load     in   capture data_in and set valid (wins over clear)
//   clear    in   drop the held beat (data is kept, only valid falls)
//   data_in  in   payload to capture
//   valid    out  entry holds a beat
//   data     out  held payload
// -----------------------------------------------------------------------------
module axis_skid_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] data_in,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  logic              valid_d, valid_q;
  logic [DATA_W-1:0] data_d,  data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = data_in;
    end else if (clear) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/axis_reg_slice.sv
// -----------------------------------------------------------------------------
// axis_reg_slice
// Parametrised valid/ready register slice.
//   MODE 0 pass-through, 1 forward-registered, 2 backward-registered,
//   3 full two-entry skid buffer (all outputs registered, no bubbles).
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   data_up/valid_up  payload and valid from master
//   ready_up          ready back to master
//   data_down/valid_down  payload and valid to slave
//   ready_down        ready from slave
//   occupancy         beats currently held (0..2)
//   stall_cnt         saturating count of cycles with valid_down & ~ready_down
//                     (present only with AXIS_REG_SLICE_STALL_CNT_EN defined)
// -----------------------------------------------------------------------------
module axis_reg_slice
  import axis_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int MODE   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_up,
  input  logic              valid_up,
  output logic              ready_up,
  output logic [DATA_W-1:0] data_down,
  output logic              valid_down,
  input  logic              ready_down,
  output logic [1:0]        occupancy
`ifdef AXIS_REG_SLICE_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

  if (!mode_is_legal(MODE)) begin : g_bad_mode
    $error("axis_reg_slice: MODE must be 0..3");
  end

  if (MODE == MODE_PASS) begin : g_pass
    assign data_down  = data_up;
    assign valid_down = valid_up;
    assign ready_up   = ready_down;
    assign occupancy  = 2'd0;

  end else if (MODE == MODE_FWD) begin : g_fwd
    logic              accept, xfer;
    logic              main_valid;
    logic [DATA_W-1:0] main_data;

    assign ready_up = ready_down | ~main_valid;
    assign accept   = valid_up & ready_up;
    assign xfer     = main_valid & ready_down;

    axis_skid_reg #(.DATA_W(DATA_W)) u_main (
      .clk     (clk),
      .rst     (rst),
      .load    (accept),
      .clear   (xfer & ~accept),
      .data_in (data_up),
      .valid   (main_valid),
      .data    (main_data)
    );

    assign valid_down = main_valid;
    assign data_down  = main_data;
    assign occupancy  = {1'b0, main_valid};

  end else if (MODE == MODE_BWD) begin : g_bwd
    logic              accept, skid_load, skid_clear;
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic              ready_up_d, ready_up_q;

    assign accept     = valid_up & ready_up_q;
    // Only park a beat when the slave refuses it; ready_up_q already implies skid empty.
    assign skid_load  = accept & ~ready_down;
    assign skid_clear = skid_valid & ready_down;
    assign ready_up_d = ~(skid_load | (skid_valid & ~skid_clear));

    axis_skid_reg #(.DATA_W(DATA_W)) u_skid (
      .clk     (clk),
      .rst     (rst),
      .load    (skid_load),
      .clear   (skid_clear),
      .data_in (data_up),
      .valid   (skid_valid),
      .data    (skid_data)
    );

    always_ff @(posedge clk) begin
      if (rst) ready_up_q <= 1'b1;
      else     ready_up_q <= ready_up_d;
    end

    assign ready_up   = ready_up_q;
    assign valid_down = valid_up | skid_valid;
    assign data_down  = skid_valid ? skid_data : data_up;
    assign occupancy  = {1'b0, skid_valid};

  end else begin : g_full
    full_state_e       state_d, state_q;
    logic              ready_up_d, ready_up_q;
    logic              accept, xfer;
    logic              main_load, main_clear, skid_load, skid_clear;
    logic [DATA_W-1:0] main_din;
    logic              main_valid, skid_valid;
    logic [DATA_W-1:0] main_data, skid_data;

    assign accept = valid_up & ready_up_q;
    assign xfer   = main_valid & ready_down;

    always_comb begin
      state_d    = state_q;
      main_load  = 1'b0;
      main_clear = 1'b0;
      main_din   = data_up;
      skid_load  = 1'b0;
      skid_clear = 1'b0;
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_load = 1'b1;
            state_d   = ONE;
          end
        end
        ONE: begin
          if (accept && xfer) begin
            main_load = 1'b1;
          end else if (accept) begin
            skid_load = 1'b1;
            state_d   = FULL;
          end else if (xfer) begin
            main_clear = 1'b1;
            state_d    = EMPTY;
          end
        end
        FULL: begin
          if (xfer) begin
            main_load  = 1'b1;
            main_din   = skid_data;
            skid_clear = 1'b1;
            state_d    = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
      ready_up_d = (state_d != FULL);
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q    <= EMPTY;
        ready_up_q <= 1'b1;
      end else begin
        state_q    <= state_d;
        ready_up_q <= ready_up_d;
      end
    end

    axis_skid_reg #(.DATA_W(DATA_W)) u_main (
      .clk     (clk),
      .rst     (rst),
      .load    (main_load),
      .clear   (main_clear),
      .data_in (main_din),
      .valid   (main_valid),
      .data    (main_data)
    );

    axis_skid_reg #(.DATA_W(DATA_W)) u_skid (
      .clk     (clk),
      .rst     (rst),
      .load    (skid_load),
      .clear   (skid_clear),
      .data_in (data_up),
      .valid   (skid_valid),
      .data    (skid_data)
    );

    // main_valid tracks state_q != EMPTY and is itself a flop.
    assign ready_up   = ready_up_q;
    assign valid_down = main_valid;
    assign data_down  = main_data;
    assign occupancy  = state_q;
  end

`ifdef AXIS_REG_SLICE_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cnt_d, stall_cnt_q;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (valid_down && !ready_down && (stall_cnt_q != {STALL_CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_axis_reg_slice.sv
// -----------------------------------------------------------------------------
// tb_axis_reg_slice
// One slice instance per mode (index = MODE), each with its own stimulus.
// Inputs are driven 1 ns after the falling edge; outputs are checked there too.
// -----------------------------------------------------------------------------
module tb_axis_reg_slice;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dup [4];
  logic        vup [4];
  logic        rdn [4];
  logic [31:0] ddn [4];
  logic        vdn [4];
  logic        rup [4];
  logic [1:0]  occ [4];
`ifdef AXIS_REG_SLICE_STALL_CNT_EN
  logic [15:0] scnt [4];
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    axis_reg_slice #(.DATA_W(32), .MODE(g)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .data_up    (dup[g]),
      .valid_up   (vup[g]),
      .ready_up   (rup[g]),
      .data_down  (ddn[g]),
      .valid_down (vdn[g]),
      .ready_down (rdn[g]),
      .occupancy  (occ[g])
`ifdef AXIS_REG_SLICE_STALL_CNT_EN
      ,
      .stall_cnt  (scnt[g])
`endif
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dup[i] = '0;
      vup[i] = 1'b0;
      rdn[i] = 1'b0;
    end
    repeat (3) step();
    rst = 1'b0;
    #1;

    // Reset state
    check("rst_full_valid", 32'(vdn[3]), 32'd0);
    check("rst_full_data",  ddn[3],      32'd0);
    check("rst_full_occ",   32'(occ[3]), 32'd0);
    check("rst_full_ready", 32'(rup[3]), 32'd1);
    check("rst_fwd_ready",  32'(rup[1]), 32'd1);
    check("rst_fwd_valid",  32'(vdn[1]), 32'd0);
    check("rst_bwd_ready",  32'(rup[2]), 32'd1);
    check("rst_bwd_occ",    32'(occ[2]), 32'd0);
`ifdef AXIS_REG_SLICE_STALL_CNT_EN
    check("rst_stall_cnt",  32'(scnt[3]), 32'd0);
`endif

    // MODE 0: pure wires
    dup[0] = 32'h1234; vup[0] = 1'b1; rdn[0] = 1'b0;
    #1;
    check("pass_data",  ddn[0],      32'h1234);
    check("pass_valid", 32'(vdn[0]), 32'd1);
    check("pass_ready", 32'(rup[0]), 32'd0);
    check("pass_occ",   32'(occ[0]), 32'd0);
    rdn[0] = 1'b1;
    #1;
    check("pass_ready_hi", 32'(rup[0]), 32'd1);

    // MODE 3: 16 back-to-back beats with ready_down high
    step();
    dup[3] = 32'd1; vup[3] = 1'b1; rdn[3] = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      check("stream_valid", 32'(vdn[3]), 32'd1);
      check("stream_data",  ddn[3],      32'(k));
      check("stream_occ",   32'(occ[3]), 32'd1);
      check("stream_ready", 32'(rup[3]), 32'd1);
      if (k < 16) dup[3] = 32'(k + 1);
      else        vup[3] = 1'b0;
    end
    step();
    check("stream_drain_valid", 32'(vdn[3]), 32'd0);
    check("stream_drain_occ",   32'(occ[3]), 32'd0);

    // MODE 3: fill both entries with the slave stalled, then drain in order
    dup[3] = 32'hA; vup[3] = 1'b1; rdn[3] = 1'b0;
    step();
    check("fill_occ1",   32'(occ[3]), 32'd1);
    check("fill_ready1", 32'(rup[3]), 32'd1);
    dup[3] = 32'hB;
    step();
    check("fill_occ2",   32'(occ[3]), 32'd2);
    check("fill_ready2", 32'(rup[3]), 32'd0);
    check("fill_head",   ddn[3],      32'hA);
    dup[3] = 32'hC;
    step();
    check("fill_hold_occ",  32'(occ[3]), 32'd2);
    check("fill_hold_head", ddn[3],      32'hA);
    rdn[3] = 1'b1;
    step();
    check("drain_b",       ddn[3],      32'hB);
    check("drain_b_valid", 32'(vdn[3]), 32'd1);
    check("drain_b_ready", 32'(rup[3]), 32'd1);
    check("drain_b_occ",   32'(occ[3]), 32'd1);
    step();
    check("drain_c",       ddn[3],      32'hC);
    check("drain_c_valid", 32'(vdn[3]), 32'd1);
    vup[3] = 1'b0;
    step();
    check("drain_done_valid", 32'(vdn[3]), 32'd0);
    check("drain_done_occ",   32'(occ[3]), 32'd0);

    // MODE 1: stalled beat stays put, idle data changes are not loaded
    dup[1] = 32'h55; vup[1] = 1'b1; rdn[1] = 1'b0;
    #1;
    check("fwd_ready_empty", 32'(rup[1]), 32'd1);
    for (int k = 0; k < 5; k++) begin
      step();
      check("fwd_stall_data",  ddn[1],      32'h55);
      check("fwd_stall_valid", 32'(vdn[1]), 32'd1);
      check("fwd_stall_ready", 32'(rup[1]), 32'd0);
      check("fwd_stall_occ",   32'(occ[1]), 32'd1);
      if (k == 0) dup[1] = 32'h66;
    end
    rdn[1] = 1'b1;
    #1;
    check("fwd_ready_comb", 32'(rup[1]), 32'd1);
    step();
    check("fwd_next_data",  ddn[1],      32'h66);
    check("fwd_next_valid", 32'(vdn[1]), 32'd1);
    vup[1] = 1'b0;
    step();
    check("fwd_empty_valid", 32'(vdn[1]), 32'd0);
    check("fwd_empty_occ",   32'(occ[1]), 32'd0);

    // MODE 2: refused beat parks in the skid register
    dup[2] = 32'h77; vup[2] = 1'b1; rdn[2] = 1'b0;
    #1;
    check("bwd_pass_valid", 32'(vdn[2]), 32'd1);
    check("bwd_pass_data",  ddn[2],      32'h77);
    step();
    check("bwd_skid_ready", 32'(rup[2]), 32'd0);
    check("bwd_skid_occ",   32'(occ[2]), 32'd1);
    dup[2] = 32'h88;
    #1;
    check("bwd_skid_data", ddn[2], 32'h77);
    step();
    check("bwd_skid_hold", ddn[2], 32'h77);
    rdn[2] = 1'b1;
    step();
    check("bwd_after_data",  ddn[2],      32'h88);
    check("bwd_after_ready", 32'(rup[2]), 32'd1);
    check("bwd_after_occ",   32'(occ[2]), 32'd0);
    vup[2] = 1'b0;
    #1;
    check("bwd_idle_valid", 32'(vdn[2]), 32'd0);

    // MODE 3: reset while full drops everything
    step();
    dup[3] = 32'hD1; vup[3] = 1'b1; rdn[3] = 1'b0;
    step();
    dup[3] = 32'hD2;
    step();
    check("rst_mid_occ2", 32'(occ[3]), 32'd2);
    dup[3] = 32'hD3;
    rst = 1'b1;
    step();
    rst = 1'b0; vup[3] = 1'b0;
    check("rst_mid_valid", 32'(vdn[3]), 32'd0);
    check("rst_mid_data",  ddn[3],      32'd0);
    check("rst_mid_occ",   32'(occ[3]), 32'd0);
    check("rst_mid_ready", 32'(rup[3]), 32'd1);
    rdn[3] = 1'b1;
    step();
    step();
    check("rst_no_stale", 32'(vdn[3]), 32'd0);

`ifdef AXIS_REG_SLICE_STALL_CNT_EN
    check("stall_cnt_cleared", 32'(scnt[3]), 32'd0);
    dup[3] = 32'hE; vup[3] = 1'b1; rdn[3] = 1'b0;
    repeat (70000) @(negedge clk);
    #1;
    check("stall_cnt_sat", 32'(scnt[3]), 32'hFFFF);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
